// File: rtl/amb_hakemi.sv
// amb_hakemi: two-requester round-robin arbiter and sequencer for one shared
// combinational ALU (aritmetik_mantik_birimi).
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   istek_gecerli_i    per-requester request valid (bit k = requester k)
//   istek_hazir_o      per-requester request ready (one-hot grant in BOSTA)
//   istek_kontrol_i    ALU op code, requester k at [k*KONTROL_BIT +: KONTROL_BIT]
//   istek_deger1_i     first operand, requester k at [k*VERI_BIT +: VERI_BIT]
//   istek_deger2_i     second operand, same slicing
//   sonuc_gecerli_o    per-requester result valid
//   sonuc_hazir_i      per-requester result ready
//   sonuc_o            registered ALU result
//   amb_kontrol_o      to ALU kontrol_i
//   amb_deger1_o       to ALU deger1_i
//   amb_deger2_o       to ALU deger2_i
//   amb_sonuc_i        from ALU sonuc_o
//   islem_sayaci_o     completed-transaction counter, wraps
module amb_hakemi #(
  parameter int unsigned VERI_BIT    = 32,
  parameter int unsigned KONTROL_BIT = 4,
  parameter int unsigned SAYAC_BIT   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [1:0]               istek_gecerli_i,
  output logic [1:0]               istek_hazir_o,
  input  logic [2*KONTROL_BIT-1:0] istek_kontrol_i,
  input  logic [2*VERI_BIT-1:0]    istek_deger1_i,
  input  logic [2*VERI_BIT-1:0]    istek_deger2_i,
  output logic [1:0]               sonuc_gecerli_o,
  input  logic [1:0]               sonuc_hazir_i,
  output logic [VERI_BIT-1:0]      sonuc_o,
  output logic [KONTROL_BIT-1:0]   amb_kontrol_o,
  output logic [VERI_BIT-1:0]      amb_deger1_o,
  output logic [VERI_BIT-1:0]      amb_deger2_o,
  input  logic [VERI_BIT-1:0]      amb_sonuc_i,
  output logic [SAYAC_BIT-1:0]     islem_sayaci_o
);

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    HESAPLA = 2'd1,
    CEVAP   = 2'd2
  } durum_t;

  durum_t durum_q, durum_d;

  logic                   oncelik_q, oncelik_d;   // requester that wins a tie
  logic                   secili_q, secili_d;     // id of the requester being served
  logic [KONTROL_BIT-1:0] kontrol_q;
  logic [VERI_BIT-1:0]    deger1_q;
  logic [VERI_BIT-1:0]    deger2_q;
  logic [VERI_BIT-1:0]    sonuc_q;
  logic [SAYAC_BIT-1:0]   sayac_q;

  logic [1:0]             kazanan;                // one-hot grant candidate
  logic                   kabul;                  // request handshake this cycle
  logic                   yakala;                 // capture ALU result this cycle
  logic                   tuket;                  // response handshake this cycle

  logic [KONTROL_BIT-1:0] kontrol_sec;
  logic [VERI_BIT-1:0]    deger1_sec;
  logic [VERI_BIT-1:0]    deger2_sec;

  // Round-robin grant: single valid wins outright, a tie goes to oncelik_q.
  always_comb begin
    kazanan = 2'b00;
    case (istek_gecerli_i)
      2'b01:   kazanan = 2'b01;
      2'b10:   kazanan = 2'b10;
      2'b11:   kazanan = oncelik_q ? 2'b10 : 2'b01;
      default: kazanan = 2'b00;
    endcase
  end

  // Payload of the granted requester.
  assign kontrol_sec = kazanan[1] ? istek_kontrol_i[2*KONTROL_BIT-1:KONTROL_BIT]
                                  : istek_kontrol_i[KONTROL_BIT-1:0];
  assign deger1_sec  = kazanan[1] ? istek_deger1_i[2*VERI_BIT-1:VERI_BIT]
                                  : istek_deger1_i[VERI_BIT-1:0];
  assign deger2_sec  = kazanan[1] ? istek_deger2_i[2*VERI_BIT-1:VERI_BIT]
                                  : istek_deger2_i[VERI_BIT-1:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_q   <= BOSTA;
      oncelik_q <= 1'b0;
      secili_q  <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      oncelik_q <= oncelik_d;
      secili_q  <= secili_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    durum_d         = durum_q;
    oncelik_d       = oncelik_q;
    secili_d        = secili_q;
    istek_hazir_o   = 2'b00;
    sonuc_gecerli_o = 2'b00;
    kabul           = 1'b0;
    yakala          = 1'b0;
    tuket           = 1'b0;
    case (durum_q)
      BOSTA: begin
        // Ready is held low while reset is asserted.
        istek_hazir_o = rst_ni ? kazanan : 2'b00;
        if (kazanan != 2'b00) begin
          kabul     = 1'b1;
          secili_d  = kazanan[1];
          oncelik_d = ~kazanan[1];
          durum_d   = HESAPLA;
        end
      end
      HESAPLA: begin
        yakala  = 1'b1;
        durum_d = CEVAP;
      end
      CEVAP: begin
        sonuc_gecerli_o = secili_q ? 2'b10 : 2'b01;
        // Only the served requester's ready completes the response.
        if (sonuc_hazir_i[secili_q]) begin
          tuket   = 1'b1;
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  // Operand/op, result and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kontrol_q <= '0;
      deger1_q  <= '0;
      deger2_q  <= '0;
      sonuc_q   <= '0;
      sayac_q   <= '0;
    end else begin
      if (kabul) begin
        kontrol_q <= kontrol_sec;
        deger1_q  <= deger1_sec;
        deger2_q  <= deger2_sec;
      end
      if (yakala) begin
        sonuc_q <= amb_sonuc_i;
      end
      if (tuket) begin
        sayac_q <= sayac_q + SAYAC_BIT'(1);
      end
    end
  end

  assign amb_kontrol_o  = kontrol_q;
  assign amb_deger1_o   = deger1_q;
  assign amb_deger2_o   = deger2_q;
  assign sonuc_o        = sonuc_q;
  assign islem_sayaci_o = sayac_q;

endmodule

// File: tb/tb_amb_hakemi.sv
// Testbench for amb_hakemi: directed tables, multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_amb_hakemi;

  localparam int unsigned VB = 32;
  localparam int unsigned KB = 4;
  localparam int unsigned SB = 16;

  localparam logic [3:0] OP_TOPLAMA = 4'd0;
  localparam logic [3:0] OP_CIKARMA = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_SRA     = 4'd5;
  localparam logic [3:0] OP_GECIR   = 4'd6;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [1:0]    req_v;
  logic [KB-1:0] req_op [2];
  logic [VB-1:0] req_a  [2];
  logic [VB-1:0] req_b  [2];

  logic [1:0]      istek_gecerli_i, istek_hazir_o, sonuc_gecerli_o, sonuc_hazir_i;
  logic [2*KB-1:0] istek_kontrol_i;
  logic [2*VB-1:0] istek_deger1_i, istek_deger2_i;
  logic [VB-1:0]   sonuc_o, amb_deger1_o, amb_deger2_o, amb_sonuc_i;
  logic [KB-1:0]   amb_kontrol_o;
  logic [SB-1:0]   islem_sayaci_o;

  logic [1:0]    hazir_w, gecerli_w;
  logic [VB-1:0] sonuc_w, deger1_w, deger2_w, amb_sonuc_w;
  logic [KB-1:0] kontrol_w;
  logic [1:0]    sayac_w;

  assign istek_gecerli_i = req_v;
  assign istek_kontrol_i = {req_op[1], req_op[0]};
  assign istek_deger1_i  = {req_a[1], req_a[0]};
  assign istek_deger2_i  = {req_b[1], req_b[0]};

  function automatic logic [VB-1:0] alu(input logic [KB-1:0] op, input logic [VB-1:0] a,
                                        input logic [VB-1:0] b);
    case (op)
      OP_TOPLAMA: return a + b;
      OP_CIKARMA: return a - b;
      OP_AND:     return a & b;
      OP_OR:      return a | b;
      OP_XOR:     return a ^ b;
      OP_SRA:     return VB'($signed(a) >>> b[4:0]);
      OP_GECIR:   return b;
      default:    return '0;
    endcase
  endfunction

  assign amb_sonuc_i = alu(amb_kontrol_o, amb_deger1_o, amb_deger2_o);
  assign amb_sonuc_w = alu(kontrol_w, deger1_w, deger2_w);

  amb_hakemi #(.VERI_BIT(VB), .KONTROL_BIT(KB), .SAYAC_BIT(SB)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
    .istek_kontrol_i(istek_kontrol_i), .istek_deger1_i(istek_deger1_i),
    .istek_deger2_i(istek_deger2_i),
    .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_hazir_i(sonuc_hazir_i), .sonuc_o(sonuc_o),
    .amb_kontrol_o(amb_kontrol_o), .amb_deger1_o(amb_deger1_o), .amb_deger2_o(amb_deger2_o),
    .amb_sonuc_i(amb_sonuc_i), .islem_sayaci_o(islem_sayaci_o)
  );

  // Narrow-counter instance sharing all stimulus, for counter wrap.
  amb_hakemi #(.VERI_BIT(VB), .KONTROL_BIT(KB), .SAYAC_BIT(2)) u_dut_w (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(hazir_w),
    .istek_kontrol_i(istek_kontrol_i), .istek_deger1_i(istek_deger1_i),
    .istek_deger2_i(istek_deger2_i),
    .sonuc_gecerli_o(gecerli_w), .sonuc_hazir_i(sonuc_hazir_i), .sonuc_o(sonuc_w),
    .amb_kontrol_o(kontrol_w), .amb_deger1_o(deger1_w), .amb_deger2_o(deger2_w),
    .amb_sonuc_i(amb_sonuc_w), .islem_sayaci_o(sayac_w)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction; result visible from the
  // second cycle after acceptance until the served requester takes it.
  logic          m_busy;
  int            m_acc;
  logic          m_id, m_prio;
  logic [KB-1:0] m_op;
  logic [VB-1:0] m_a, m_b, m_res;
  logic [SB-1:0] m_cnt;
  int            cyc = 0;
  logic [1:0]    last_hs;

  function automatic logic [1:0] grant_of(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_acc = 0; m_id = 1'b0; m_prio = 1'b0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_cnt = '0;
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic tick();
    logic [1:0] hz, gv;
    logic       resp;
    #1;
    resp = m_busy && (cyc >= m_acc + 1);
    hz   = m_busy ? 2'b00 : grant_of(req_v, m_prio);
    gv   = resp ? (m_id ? 2'b10 : 2'b01) : 2'b00;
    chk("m_hazir", istek_hazir_o, hz);
    chk("m_gecerli", sonuc_gecerli_o, gv);
    chk("m_gecerli_w", gecerli_w, gv);
    if (resp) chk("m_sonuc", sonuc_o, m_res);
    chk("m_kontrol", amb_kontrol_o, m_op);
    chk("m_deger1", amb_deger1_o, m_a);
    chk("m_deger2", amb_deger2_o, m_b);
    chk("m_sayac", islem_sayaci_o, m_cnt);
    chk("m_sayac_w", sayac_w, m_cnt[1:0]);
    last_hs = hz;
    if (hz != 2'b00) begin
      m_busy = 1'b1; m_acc = cyc + 1; m_id = hz[1]; m_prio = ~hz[1];
      m_op = req_op[hz[1]]; m_a = req_a[hz[1]]; m_b = req_b[hz[1]];
      m_res = alu(m_op, m_a, m_b);
    end else if (resp && sonuc_hazir_i[m_id]) begin
      m_busy = 1'b0;
      m_cnt  = m_cnt + 16'd1;
    end
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    req_v = 2'b00; sonuc_hazir_i = 2'b00;
    rst_ni = 1'b0;
    req_v[0] = 1'b1;
    #1;
    chk("rst_hazir_gated", istek_hazir_o, 2'b00);
    req_v[0] = 1'b0;
    model_reset();
    #1;
    chk("rst_gecerli", sonuc_gecerli_o, 2'b00);
    chk("rst_sonuc", sonuc_o, 0);
    chk("rst_sayac", islem_sayaci_o, 0);
    chk("rst_deger1", amb_deger1_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Single-requester transaction with fixed expected result.
  task automatic do_txn(input logic rq, input logic [KB-1:0] op, input logic [VB-1:0] a,
                        input logic [VB-1:0] b, input logic [VB-1:0] exp, input string nm);
    req_op[rq] = op; req_a[rq] = a; req_b[rq] = b; req_v[rq] = 1'b1;
    sonuc_hazir_i = 2'b11;
    #1;
    chk({nm, "_hazir"}, istek_hazir_o, rq ? 2'b10 : 2'b01);
    tick();
    req_v[rq] = 1'b0;
    tick();
    #1;
    chk({nm, "_gecerli"}, sonuc_gecerli_o, rq ? 2'b10 : 2'b01);
    chk({nm, "_sonuc"}, sonuc_o, exp);
    tick();
  endtask

  typedef struct {
    logic          rq;
    logic [KB-1:0] op;
    logic [VB-1:0] a;
    logic [VB-1:0] b;
    logic [VB-1:0] exp;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ord [4];
    logic [1:0] g;
    logic [1:0] wrap_exp [5];
    int         n;

    req_v = 2'b00; sonuc_hazir_i = 2'b00;
    for (int k = 0; k < 2; k++) begin
      req_op[k] = '0; req_a[k] = '0; req_b[k] = '0;
    end
    last_hs = 2'b00;
    model_reset();

    tbl[0] = '{1'b0, OP_TOPLAMA, 32'd80,         32'd70,         32'd150};
    tbl[1] = '{1'b1, OP_CIKARMA, 32'd100,        32'd1,          32'd99};
    tbl[2] = '{1'b0, OP_XOR,     32'hf0f0_f0f0,  32'hff0f_0f0f,  32'h0fff_ffff};
    tbl[3] = '{1'b1, OP_AND,     32'hf0f0_f0f0,  32'hff0f_0f0f,  32'hf000_0000};
    tbl[4] = '{1'b0, OP_SRA,     32'hf0f0_f0f0,  32'd4,          32'hff0f_0f0f};
    tbl[5] = '{1'b1, OP_OR,      32'h0000_ffff,  32'hff00_0000,  32'hff00_ffff};
    tbl[6] = '{1'b0, OP_TOPLAMA, 32'hffff_ffff,  32'd1,          32'd0};

    #2;
    do_reset();

    // Directed single-requester vectors.
    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].rq, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));
      #1;
      chk("tbl_sayac", islem_sayaci_o, 64'(i + 1));
    end

    // Reset during the compute cycle discards the transaction.
    req_op[0] = OP_TOPLAMA; req_a[0] = 32'd1; req_b[0] = 32'd2; req_v[0] = 1'b1;
    sonuc_hazir_i = 2'b11;
    tick();
    req_v[0] = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rmid_gecerli", sonuc_gecerli_o, 2'b00);
    chk("rmid_hazir", istek_hazir_o, 2'b00);
    chk("rmid_sonuc", sonuc_o, 0);
    chk("rmid_deger1", amb_deger1_o, 0);
    chk("rmid_sayac", islem_sayaci_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rmid_nopulse", sonuc_gecerli_o, 2'b00);
      tick();
    end
    do_txn(1'b0, OP_TOPLAMA, 32'd5, 32'd6, 32'd11, "rmid_next");

    // Tie after reset: requester 0 first, then requester 1.
    do_reset();
    req_op[0] = OP_XOR; req_a[0] = 32'hf0f0_f0f0; req_b[0] = 32'hff0f_0f0f;
    req_op[1] = OP_AND; req_a[1] = 32'hf0f0_f0f0; req_b[1] = 32'hff0f_0f0f;
    req_v = 2'b11; sonuc_hazir_i = 2'b11;
    #1;
    chk("tie_hazir0", istek_hazir_o, 2'b01);
    tick();
    req_v[0] = 1'b0;
    tick();
    #1;
    chk("tie_gecerli0", sonuc_gecerli_o, 2'b01);
    chk("tie_sonuc0", sonuc_o, 32'h0fff_ffff);
    tick();
    #1;
    chk("tie_hazir1", istek_hazir_o, 2'b10);
    tick();
    req_v[1] = 1'b0;
    tick();
    #1;
    chk("tie_gecerli1", sonuc_gecerli_o, 2'b10);
    chk("tie_sonuc1", sonuc_o, 32'hf000_0000);
    tick();

    // Fairness with both requesters continuously valid.
    do_reset();
    req_op[0] = OP_GECIR; req_a[0] = 32'd0; req_b[0] = 32'd10;
    req_op[1] = OP_GECIR; req_a[1] = 32'd0; req_b[1] = 32'd20;
    req_v = 2'b11; sonuc_hazir_i = 2'b11;
    n = 0;
    for (int t = 0; t < 40 && (n < 4 || m_busy); t++) begin
      #1;
      g = istek_hazir_o;
      tick();
      if (g != 2'b00 && n < 4) begin
        ord[n] = g;
        n++;
        if (n == 4) req_v = 2'b00;
      end
    end
    chk("fair_grants", 64'(n), 64'd4);
    for (int k = 0; k < 4 && k < n; k++)
      chk($sformatf("fair_order%0d", k), ord[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    #1;
    chk("fair_sayac", islem_sayaci_o, 64'd4);

    // Backpressure on requester 1; requester 0 waits through it.
    do_reset();
    req_op[1] = OP_SRA; req_a[1] = 32'hf0f0_f0f0; req_b[1] = 32'd4; req_v[1] = 1'b1;
    sonuc_hazir_i = 2'b00;
    tick();
    req_v[1] = 1'b0;
    req_op[0] = OP_GECIR; req_a[0] = 32'd0; req_b[0] = 32'h1234; req_v[0] = 1'b1;
    tick();
    sonuc_hazir_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_sonuc", sonuc_o, 32'hff0f_0f0f);
      chk("bp_hazir", istek_hazir_o, 2'b00);
      chk("bp_gecerli", sonuc_gecerli_o, 2'b10);
      tick();
    end
    sonuc_hazir_i = 2'b11;
    tick();
    #1;
    chk("bp_next_hazir", istek_hazir_o, 2'b01);
    tick();
    req_v[0] = 1'b0;
    tick();
    #1;
    chk("bp_next_sonuc", sonuc_o, 32'h1234);
    tick();

    // Counter wrap on the 2-bit instance.
    do_reset();
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    for (int i = 0; i < 5; i++) begin
      do_txn(1'(i % 2), OP_GECIR, 32'hdead_0000, VB'(i * 32'h111 + 7), VB'(i * 32'h111 + 7),
             $sformatf("wrap%0d", i));
      #1;
      chk("wrap_sayac", sayac_w, wrap_exp[i]);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req_v[k]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_op[k] = 4'($urandom_range(0, 6));
            req_a[k]  = $urandom;
            req_b[k]  = $urandom;
            req_v[k]  = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[k] = 1'b0;
        end
      end
      sonuc_hazir_i = 2'($urandom_range(0, 3));
      tick();
      for (int k = 0; k < 2; k++)
        if (last_hs[k]) req_v[k] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
